snake_body_ctrl: RTL and testbench
==================================

Name: snake_body_ctrl

Overview:
Snake movement and collision stage for the 16x16 playfield. It sits directly upstream of the apple generator.
- Holds the snake segment list and advances it on each move tick.
- Detects apple, wall and self collisions.
- Drives the body[] array and the good_coll strobe that the apple generator consumes.
- Cell coordinates are 8 bits, {x[3:0], y[3:0]}.

Parameters:
MAX_LENGTH, 16, number of segment slots in body[] (must be >= 4)
LW, $clog2(MAX_LENGTH+1), width of the length output

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
s_reset  input  1  synchronous game restart, active-high, one-cycle pulse or level
tick  input  1  move strobe, one clk cycle wide
btn  input  4  direction buttons {up, down, left, right}, already debounced, active-high
apple_cord  input  8  current apple cell {x, y} from the apple generator
body  output  [MAX_LENGTH-1:0][7:0]  segment cells; body[0] is the head
length  output  LW  number of live segments
good_coll  output  1  one-cycle pulse: head moved onto the apple
bad_coll  output  1  level: game over (wall or self hit)
running  output  1  high in RUN state

Behaviour:
- Reset and s_reset take the block to the same initial state. s_reset is sampled on posedge clk; reset is asynchronous. Initial state:
  - state = IDLE; length = 3
  - body[0] = 8'h35, body[1] = 8'h25, body[2] = 8'h15
  - all slots i >= 3 = 8'h15 (tail copy)
  - cur_dir = RIGHT, pend_dir = RIGHT
  - good_coll = 0, bad_coll = 0, running = 0
- Slot fill rule: every slot i >= length always equals body[length-1]. Unused slots therefore never name an unoccupied cell, and the apple generator may compare against all MAX_LENGTH slots.
- States:
  - IDLE -> RUN: first cycle in which btn is exactly one-hot. That button is loaded into pend_dir, except LEFT, which is reversal-blocked because cur_dir = RIGHT. tick is ignored in IDLE.
  - RUN -> DEAD: a move that produces a wall or self collision.
  - DEAD: body and length frozen; bad_coll = 1; only reset or s_reset exit.
- Direction latch:
  - In IDLE and RUN, a one-hot btn that is not the reverse of cur_dir loads pend_dir.
  - Zero or multiple buttons pressed: pend_dir is unchanged.
  - On each move, cur_dir <= pend_dir.
- Move (RUN, tick = 1), all effects on the same posedge:
  - Next head nh = body[0] stepped one cell in pend_dir. Up is y-1, down is y+1, left is x-1, right is x+1.
  - Wall: a step that would leave 0..15 on either axis (no wrap) -> DEAD. body and length are not modified.
  - grow = (nh == apple_cord) and no wall hit.
  - Self hit: nh equals body[i] for any i in 0..length-2. If grow, the check also includes i = length-1, because the tail does not vacate. Hit -> DEAD, no body update.
  - Otherwise, shift: body[i] <= body[i-1] for i = 1..MAX_LENGTH-1, body[0] <= nh.
  - If grow and length < MAX_LENGTH: length <= length+1, and the old tail cell is retained as the new tail.
  - Then re-apply the fill rule.
  - good_coll is registered: high exactly in the cycle after the move edge, for one cycle.
  - grow at length == MAX_LENGTH: good_coll still pulses, length saturates, and the snake moves without growing.
- Latency: body, length and bad_coll reflect a tick one cycle after the tick is sampled. good_coll is aligned with the updated body, so the apple generator sees the new head in body[] when it picks a new apple.
- Simultaneous events:
  - s_reset with tick: s_reset wins.
  - btn change with tick: the move uses the pend_dir value held before that edge; the new button loads for the next move.
  - tick in DEAD or IDLE: ignored.
- Reset mid-move (reset asserted asynchronously): all outputs go to their initial values immediately, and any pending good_coll is dropped.

Test Plan:
- Reset, then press right, then 3 ticks -> running = 1; body[0..2] = 8'h65, 8'h55, 8'h45; length = 3; slots >= 3 = 8'h45; good_coll never high.
- apple_cord = 8'h45 from the initial state; press right; 1 tick -> next cycle: body[0] = 8'h45, body[3] = 8'h15, length = 4, good_coll high for exactly 1 cycle.
- From the initial state press left (reversal) then up; tick -> body[0] = 8'h34. Pressing left+up together alone leaves pend_dir = RIGHT.
- Run right until x = 15 (body[0] = 8'hF5), then 1 more tick -> bad_coll = 1; body[0] stays 8'hF5. Further ticks change nothing; s_reset restores the initial state.
- Grow to length 5, then steer down, left, up into the body -> bad_coll on the turning tick. Separately: length 4, head circling into the just-vacated tail cell without apple -> no bad_coll.
- MAX_LENGTH = 4: eat 2 apples -> length saturates at 4, second good_coll still pulses. Also: s_reset asserted in the same cycle as tick -> initial state, no move.

Source files
------------

// File: rtl/snake_body_if.sv
// Handshake bundle between the snake body stage and its neighbours: game
// control inputs in, segment list and collision status out.
interface snake_body_if #(
    parameter int MAX_LENGTH = 16,
    parameter int LW         = $clog2(MAX_LENGTH + 1)
);
    logic                       s_reset;
    logic                       tick;
    logic [3:0]                 btn;
    logic [7:0]                 apple_cord;
    logic [MAX_LENGTH-1:0][7:0] body;
    logic [LW-1:0]              length;
    logic                       good_coll;
    logic                       bad_coll;
    logic                       running;

    modport master (
        output s_reset, tick, btn, apple_cord,
        input  body, length, good_coll, bad_coll, running
    );

    modport slave (
        input  s_reset, tick, btn, apple_cord,
        output body, length, good_coll, bad_coll, running
    );
endinterface

// File: rtl/snake_body_ctrl.sv
// Snake movement and collision stage for the 16x16 playfield. Keeps the
// segment list (body[0] = head), advances it on each tick and flags apple,
// wall and self collisions. Cells are {x[3:0], y[3:0]}.
module snake_body_ctrl #(
    parameter int MAX_LENGTH = 16,
    parameter int LW         = $clog2(MAX_LENGTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    snake_body_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2} state_t;

    // Directions share the button encoding {up, down, left, right}.
    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    localparam logic [LW-1:0] INIT_LEN = LW'(3);
    localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_LENGTH);

    function automatic logic [MAX_LENGTH-1:0][7:0] init_body();
        logic [MAX_LENGTH-1:0][7:0] r;
        for (int i = 0; i < MAX_LENGTH; i++) r[i] = 8'h15;
        r[0] = 8'h35;
        r[1] = 8'h25;
        return r;
    endfunction

    localparam logic [MAX_LENGTH-1:0][7:0] INIT_BODY = init_body();

    state_t                     state;
    logic [3:0]                 cur_dir;
    logic [3:0]                 pend_dir;
    logic [MAX_LENGTH-1:0][7:0] body_q;
    logic [LW-1:0]              len_q;
    logic                       good_q;
    logic                       bad_q;
    logic                       run_q;

    logic                       btn_one;
    logic                       btn_ok;
    logic [3:0]                 hx;
    logic [3:0]                 hy;
    logic [7:0]                 nh;
    logic                       wall;
    logic                       grow;
    logic                       self_hit;
    logic [MAX_LENGTH-1:0][7:0] shifted;
    logic [MAX_LENGTH-1:0][7:0] body_nxt;
    logic [LW-1:0]              len_nxt;
    logic [7:0]                 tail_nxt;

    // Button filter: exactly one button, and not a reversal of the current heading.
    always_comb begin
        btn_one = $onehot(bus.btn);
        btn_ok  = btn_one && (bus.btn != {cur_dir[2], cur_dir[3], cur_dir[0], cur_dir[1]});
    end

    // Candidate head one cell along pend_dir; a step off the board is a wall hit.
    always_comb begin
        hx   = body_q[0][7:4];
        hy   = body_q[0][3:0];
        nh   = body_q[0];
        wall = 1'b0;
        case (pend_dir)
            DIR_UP:    begin wall = (hy == 4'd0);  nh = {hx, hy - 4'd1}; end
            DIR_DOWN:  begin wall = (hy == 4'd15); nh = {hx, hy + 4'd1}; end
            DIR_LEFT:  begin wall = (hx == 4'd0);  nh = {hx - 4'd1, hy}; end
            DIR_RIGHT: begin wall = (hx == 4'd15); nh = {hx + 4'd1, hy}; end
            default:   ;
        endcase
        grow = (nh == bus.apple_cord) && !wall;
    end

    // Self hit: the tail cell only counts when growing, since it does not vacate then.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LENGTH; i++) begin
            if ((grow ? (LW'(i + 1) <= len_q) : (LW'(i + 1) < len_q)) && body_q[i] == nh)
                self_hit = 1'b1;
        end
    end

    // Shifted body with new head, grown length, and tail copy into every unused slot.
    always_comb begin
        shifted[0] = nh;
        for (int i = 1; i < MAX_LENGTH; i++) shifted[i] = body_q[i-1];
        len_nxt  = (grow && len_q != MAX_LEN) ? len_q + LW'(1) : len_q;
        tail_nxt = shifted[0];
        for (int i = 0; i < MAX_LENGTH; i++) begin
            if (LW'(i + 1) == len_nxt) tail_nxt = shifted[i];
        end
        for (int i = 0; i < MAX_LENGTH; i++) begin
            body_nxt[i] = (LW'(i) >= len_nxt) ? tail_nxt : shifted[i];
        end
    end

    // Game FSM with registered outputs; s_reset outranks any move on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cur_dir  <= DIR_RIGHT;
            pend_dir <= DIR_RIGHT;
            body_q   <= INIT_BODY;
            len_q    <= INIT_LEN;
            good_q   <= 1'b0;
            bad_q    <= 1'b0;
            run_q    <= 1'b0;
        end else if (bus.s_reset) begin
            state    <= IDLE;
            cur_dir  <= DIR_RIGHT;
            pend_dir <= DIR_RIGHT;
            body_q   <= INIT_BODY;
            len_q    <= INIT_LEN;
            good_q   <= 1'b0;
            bad_q    <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            good_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_ok) pend_dir <= bus.btn;
                    if (btn_one) begin
                        state <= RUN;
                        run_q <= 1'b1;
                    end
                end
                RUN: begin
                    // A button on a tick edge only affects the following move.
                    if (btn_ok) pend_dir <= bus.btn;
                    if (bus.tick) begin
                        cur_dir <= pend_dir;
                        if (wall || self_hit) begin
                            state <= DEAD;
                            run_q <= 1'b0;
                            bad_q <= 1'b1;
                        end else begin
                            body_q <= body_nxt;
                            len_q  <= len_nxt;
                            good_q <= grow;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.body      = body_q;
    assign bus.length    = len_q;
    assign bus.good_coll = good_q;
    assign bus.bad_coll  = bad_q;
    assign bus.running   = run_q;
endmodule

// File: tb/tb_snake_body_ctrl.sv
// Bench for snake_body_ctrl: two instances (MAX_LENGTH 16 and 4) run in
// lockstep against a queue-based snake model, directed steps then random play.
module tb_snake_body_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       s_reset;
    logic       tick;
    logic [3:0] btn;
    logic [7:0] apple_cord;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] B_UP = 4'b1000, B_DOWN = 4'b0100, B_LEFT = 4'b0010, B_RIGHT = 4'b0001;

    always #5 clk = ~clk;

    snake_body_if #(.MAX_LENGTH(16)) bif ();
    snake_body_if #(.MAX_LENGTH(4))  bif4 ();

    assign bif.s_reset     = s_reset;
    assign bif.tick        = tick;
    assign bif.btn         = btn;
    assign bif.apple_cord  = apple_cord;
    assign bif4.s_reset    = s_reset;
    assign bif4.tick       = tick;
    assign bif4.btn        = btn;
    assign bif4.apple_cord = apple_cord;

    snake_body_ctrl #(.MAX_LENGTH(16)) dut  (.clk(clk), .reset(reset), .bus(bif.slave));
    snake_body_ctrl #(.MAX_LENGTH(4))  dut4 (.clk(clk), .reset(reset), .bus(bif4.slave));

    // Model: snake as a list of cells head-first; directions 0 up, 1 down, 2 left, 3 right.
    typedef logic [7:0] cell_q_t[$];
    cell_q_t mq[2];
    int      mst[2];
    int      mcur[2];
    int      mpend[2];
    bit      mgood[2];

    task automatic m_init(input int k);
        mq[k]    = '{8'h35, 8'h25, 8'h15};
        mst[k]   = 0;
        mcur[k]  = 3;
        mpend[k] = 3;
        mgood[k] = 0;
    endtask

    function automatic int bdir(input logic [3:0] b);
        if (b[3]) return 0;
        if (b[2]) return 1;
        if (b[1]) return 2;
        return 3;
    endfunction

    task automatic m_edge(input int k);
        int mx, x, y, n, d, cur_old;
        bit one, hit, grow;
        logic [7:0] h, nh;
        mx = (k == 0) ? 16 : 4;
        mgood[k] = 0;
        if (s_reset) begin
            m_init(k);
            return;
        end
        one = ($countones(btn) == 1);
        d   = bdir(btn);
        cur_old = mcur[k];
        if (mst[k] == 0) begin
            if (one) begin
                mst[k] = 1;
                if (d != (cur_old ^ 1)) mpend[k] = d;
            end
        end else if (mst[k] == 1) begin
            if (tick) begin
                h = mq[k][0];
                x = int'(h[7:4]);
                y = int'(h[3:0]);
                case (mpend[k])
                    0: y = y - 1;
                    1: y = y + 1;
                    2: x = x - 1;
                    default: x = x + 1;
                endcase
                n = mq[k].size();
                if (x < 0 || x > 15 || y < 0 || y > 15) begin
                    mst[k] = 2;
                end else begin
                    nh   = {x[3:0], y[3:0]};
                    grow = (nh == apple_cord);
                    hit  = 0;
                    for (int i = 0; i < n; i++)
                        if (mq[k][i] == nh && (i < n - 1 || grow)) hit = 1;
                    if (hit) mst[k] = 2;
                    else begin
                        mq[k].push_front(nh);
                        if (!grow || n == mx) void'(mq[k].pop_back());
                        mgood[k] = grow;
                    end
                end
                mcur[k] = mpend[k];
            end
            if (one && d != (cur_old ^ 1)) mpend[k] = d;
        end
    endtask

    function automatic logic [15:0][7:0] m_body(input int k);
        logic [15:0][7:0] r;
        int n;
        n = mq[k].size();
        for (int i = 0; i < 16; i++) r[i] = (i < n) ? mq[k][i] : mq[k][n-1];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [15:0][7:0] e0, e1;
        e0 = m_body(0);
        e1 = m_body(1);
        chk("body16",    128'(bif.body),       128'(e0));
        chk("len16",     128'(bif.length),     128'(mq[0].size()));
        chk("good16",    128'(bif.good_coll),  128'(mgood[0]));
        chk("bad16",     128'(bif.bad_coll),   128'(mst[0] == 2));
        chk("run16",     128'(bif.running),    128'(mst[0] == 1));
        chk("body4",     128'(bif4.body),      128'(e1[3:0]));
        chk("len4",      128'(bif4.length),    128'(mq[1].size()));
        chk("good4",     128'(bif4.good_coll), 128'(mgood[1]));
        chk("bad4",      128'(bif4.bad_coll),  128'(mst[1] == 2));
        chk("run4",      128'(bif4.running),   128'(mst[1] == 1));
    endtask

    // One clock: inputs were set at the preceding negedge; model follows the edge.
    task automatic cyc(input logic sr, input logic t, input logic [3:0] b, input logic [7:0] a);
        s_reset = sr; tick = t; btn = b; apple_cord = a;
        @(posedge clk);
        m_edge(0);
        m_edge(1);
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        logic       sr, t;
        logic [3:0] b;
        logic [7:0] a;
        int         r;
        logic [7:0] offs [4];
        offs = '{8'h10, 8'hF0, 8'h01, 8'hFF};

        reset = 1'b0; s_reset = 1'b0; tick = 1'b0; btn = 4'b0; apple_cord = 8'h00;
        m_init(0); m_init(1);
        #12;
        check_all();
        chk("rst_head", 128'(bif.body[0]), 128'(8'h35));
        chk("rst_slot5", 128'(bif.body[5]), 128'(8'h15));
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 1, 4'b0, 8'h00);              // tick in IDLE is ignored

        // Start right, three moves
        cyc(0, 0, B_RIGHT, 8'h00);
        chk("start_run", 128'(bif.running), 128'(1));
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 4'b0, 8'h00);
            cyc(0, 0, 4'b0, 8'h00);
        end
        chk("p1_h0", 128'(bif.body[0]), 128'(8'h65));
        chk("p1_h2", 128'(bif.body[2]), 128'(8'h45));
        chk("p1_fill", 128'(bif.body[9]), 128'(8'h45));

        // Eat apple straight ahead
        cyc(1, 0, 4'b0, 8'h45);
        cyc(0, 0, B_RIGHT, 8'h45);
        cyc(0, 1, 4'b0, 8'h45);
        chk("eat_good", 128'(bif.good_coll), 128'(1));
        chk("eat_len", 128'(bif.length), 128'(4));
        chk("eat_tail", 128'(bif.body[3]), 128'(8'h15));
        cyc(0, 0, 4'b0, 8'h00);
        chk("eat_pulse", 128'(bif.good_coll), 128'(0));

        // Reversal blocked, then up
        cyc(1, 0, 4'b0, 8'h00);
        cyc(0, 0, B_LEFT, 8'h00);
        cyc(0, 0, B_UP, 8'h00);
        cyc(0, 1, 4'b0, 8'h00);
        chk("turn_up", 128'(bif.body[0]), 128'(8'h34));
        // Two buttons together leave the heading alone
        cyc(1, 0, 4'b0, 8'h00);
        cyc(0, 0, B_RIGHT, 8'h00);
        cyc(0, 0, B_LEFT | B_UP, 8'h00);
        cyc(0, 1, 4'b0, 8'h00);
        chk("multi_btn", 128'(bif.body[0]), 128'(8'h45));

        // Wall on the right edge
        cyc(1, 0, 4'b0, 8'h00);
        cyc(0, 0, B_RIGHT, 8'h00);
        for (int i = 0; i < 12; i++) cyc(0, 1, 4'b0, 8'h00);
        chk("edge_head", 128'(bif.body[0]), 128'(8'hF5));
        chk("edge_alive", 128'(bif.bad_coll), 128'(0));
        cyc(0, 1, 4'b0, 8'h00);
        chk("wall_bad", 128'(bif.bad_coll), 128'(1));
        chk("wall_head", 128'(bif.body[0]), 128'(8'hF5));
        for (int i = 0; i < 3; i++) cyc(0, 1, B_UP, 8'h00);
        cyc(1, 0, 4'b0, 8'h00);
        chk("restart_head", 128'(bif.body[0]), 128'(8'h35));

        // Grow to 5, then curl into the body; the 4-slot instance saturates instead
        cyc(0, 0, B_RIGHT, 8'h45);
        cyc(0, 1, 4'b0, 8'h45);
        cyc(0, 1, 4'b0, 8'h55);
        chk("grow5_len", 128'(bif.length), 128'(5));
        chk("sat_good4", 128'(bif4.good_coll), 128'(1));
        chk("sat_len4", 128'(bif4.length), 128'(4));
        cyc(0, 0, B_DOWN, 8'h00);  cyc(0, 1, 4'b0, 8'h00);
        cyc(0, 0, B_LEFT, 8'h00);  cyc(0, 1, 4'b0, 8'h00);
        cyc(0, 0, B_UP, 8'h00);    cyc(0, 1, 4'b0, 8'h00);
        chk("self_bad", 128'(bif.bad_coll), 128'(1));
        chk("self_body", 128'(bif.body[0]), 128'(8'h46));

        // Length 4 chasing its own vacating tail is legal
        cyc(1, 0, 4'b0, 8'h00);
        cyc(0, 0, B_RIGHT, 8'h45);
        cyc(0, 1, 4'b0, 8'h45);
        cyc(0, 0, B_DOWN, 8'h00);  cyc(0, 1, 4'b0, 8'h00);
        cyc(0, 0, B_LEFT, 8'h00);  cyc(0, 1, 4'b0, 8'h00);
        cyc(0, 0, B_UP, 8'h00);    cyc(0, 1, 4'b0, 8'h00);
        chk("tail_ok", 128'(bif.bad_coll), 128'(0));
        chk("tail_head", 128'(bif.body[0]), 128'(8'h35));

        // s_reset together with tick: restart wins
        cyc(1, 1, 4'b0, 8'h00);
        chk("sr_tick", 128'(bif.body[0]), 128'(8'h35));

        // Asynchronous reset while good_coll is high
        cyc(0, 0, B_RIGHT, 8'h45);
        cyc(0, 1, 4'b0, 8'h45);
        chk("pre_async", 128'(bif.good_coll), 128'(1));
        reset = 1'b0;
        #1;
        m_init(0); m_init(1);
        check_all();
        chk("async_good", 128'(bif.good_coll), 128'(0));
        #2 reset = 1'b1;
        cyc(0, 0, 4'b0, 8'h00);

        // Random play
        for (int n = 0; n < 3000; n++) begin
            sr = ((mst[0] == 2 || mst[1] == 2) && $urandom_range(0, 7) == 0) ||
                 ($urandom_range(0, 299) == 0);
            r  = $urandom_range(0, 9);
            b  = (r < 6) ? 4'b0 : (r < 9) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            t  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) == 0) a = mq[0][0] + offs[$urandom_range(0, 3)];
            else a = 8'($urandom);
            cyc(sr, t, b, a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
